// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side adapter turning a 1-cycle-latency FIFO read port into a valid/ready stream
//
// Purpose: issues FIFO reads only when the small circular output buffer is
// guaranteed to have room for every word already in flight. This lets the
// stream consumer stall on any cycle while still sustaining 1 beat/cycle.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   fifo_empty      - FIFO empty flag (registered in the FIFO)
//   fifo_read_en    - FIFO read strobe, one word per asserted cycle
//   fifo_read_data  - FIFO SRAM output, valid the cycle after fifo_read_en
//   m_valid/m_ready - stream handshake
//   m_data          - head of the output buffer
//   buf_count       - entries currently held in the output buffer
//   beat_count      - accepted stream beats, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fifo_empty,
  output logic                               fifo_read_en,
  input  logic [DATA_WIDTH-1:0]              fifo_read_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count,
  output logic [CNT_WIDTH-1:0]               beat_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = $clog2(BUF_DEPTH + 2);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;

  logic                  pop;
  logic [SUM_W-1:0]      occ_after;

  always_comb begin
    m_valid      = (occ_q != '0);
    m_data       = mem_q[rd_ptr_q];
    buf_count    = occ_q;
    beat_count   = beat_q;

    pop          = m_valid & m_ready;
    // Occupancy at the end of this cycle, counting the word arriving now.
    // pop implies occ_q >= 1, so the subtraction cannot underflow.
    occ_after    = SUM_W'(occ_q) + SUM_W'(inflight_q) - SUM_W'(pop);
    // A read issued now lands next cycle; only issue if that slot is free.
    fifo_read_en = ~fifo_empty & (occ_after < SUM_W'(BUF_DEPTH));

    inflight_d   = fifo_read_en;
    occ_d        = OCC_W'(occ_after);

    wr_ptr_d     = wr_ptr_q;
    if (inflight_q) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    rd_ptr_d     = rd_ptr_q;
    beat_d       = beat_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      beat_d   = beat_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  // Capture is unconditional: the issue rule already reserved the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (inflight_q) begin
      mem_q[wr_ptr_q] <= fifo_read_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight_q && (occ_q == OCC_W'(BUF_DEPTH)) && !pop));

endmodule
